game_state_ctrl: RTL and testbench

- Game-result generator: the producer side of the end-screen colour mapper's status interface.
- Tracks one round of play: score, lives and a frame-based round timer.
- Decides win or loss and drives is_won, is_lost, score and BCD digits, all registered and held stable for the whole end screen.
- Sits between the gameplay logic (point/hit event pulses) and the end-screen colour mapper.
- Advances its round timer on VGA frame boundaries.

---
 rtl/game_state_ctrl.sv | 178 +++++++++++++++++
 tb/tb_game_state_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//
// Game-result generator feeding the end-screen colour mapper. Tracks one round
// of play (score, lives, frame-based round timer), decides win/loss and holds
// the result registered and stable for the whole end screen.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   frame_clk    VGA vsync, already synchronous to Clk; rising edge = 1 frame
//   start        start/restart key level (edge-detected internally)
//   point_pulse  one-Clk pulse, +1 point
//   hit_pulse    one-Clk pulse, -1 life
//   is_playing   high in PLAY
//   is_won       high in WON
//   is_lost      high in LOST
//   score        binary score 0..99
//   score_tens   BCD tens digit of score
//   score_ones   BCD ones digit of score
//   lives        remaining lives
//   time_left    frames remaining in the round
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int WIN_SCORE       = 20,
    parameter int START_LIVES     = 3,
    parameter int ROUND_FRAMES    = 1800,
    parameter int END_HOLD_FRAMES = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        point_pulse,
    input  logic        hit_pulse,
    output logic        is_playing,
    output logic        is_won,
    output logic        is_lost,
    output logic [6:0]  score,
    output logic [3:0]  score_tens,
    output logic [3:0]  score_ones,
    output logic [2:0]  lives,
    output logic [10:0] time_left
);

    // hold counter only needs to reach END_HOLD_FRAMES; keep at least one bit
    localparam int HOLD_W = (END_HOLD_FRAMES < 2) ? 1 : $clog2(END_HOLD_FRAMES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WON  = 2'd2;
    localparam logic [1:0] S_LOST = 2'd3;

    localparam logic [6:0]        WIN_V    = 7'(WIN_SCORE);
    localparam logic [6:0]        SCORE_MX = 7'd99;
    localparam logic [2:0]        LIVES_V  = 3'(START_LIVES);
    localparam logic [10:0]       FRAMES_V = 11'(ROUND_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(END_HOLD_FRAMES);

    logic [1:0]        state;
    logic              frame_q;
    logic              start_q;
    logic [HOLD_W-1:0] hold_cnt;

    logic              tick;
    logic              start_edge;
    logic [6:0]        score_nx;
    logic [3:0]        tens_nx;
    logic [3:0]        ones_nx;
    logic [2:0]        lives_nx;
    logic [10:0]       time_nx;

    assign tick       = frame_clk & ~frame_q;
    assign start_edge = start & ~start_q;

    // PLAY-time updates. Exit decisions are taken on these post-update values,
    // so a pulse that reaches the win/loss condition is seen in the same edge.
    always_comb begin
        score_nx = score;
        tens_nx  = score_tens;
        ones_nx  = score_ones;
        if (point_pulse && (score < SCORE_MX)) begin
            score_nx = score + 7'd1;
            // BCD runs alongside the binary count so it never needs a divider
            if (score_ones == 4'd9) begin
                ones_nx = 4'd0;
                tens_nx = score_tens + 4'd1;
            end else begin
                ones_nx = score_ones + 4'd1;
            end
        end
    end

    always_comb begin
        lives_nx = lives;
        if (hit_pulse && (lives != 3'd0))
            lives_nx = lives - 3'd1;
    end

    always_comb begin
        time_nx = time_left;
        if (tick && (time_left != 11'd0))
            time_nx = time_left - 11'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            is_playing <= 1'b0;
            is_won     <= 1'b0;
            is_lost    <= 1'b0;
            score      <= 7'd0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            lives      <= LIVES_V;
            time_left  <= FRAMES_V;
            hold_cnt   <= '0;
            frame_q    <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            start_q <= start;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state      <= S_PLAY;
                        is_playing <= 1'b1;
                        score      <= 7'd0;
                        score_tens <= 4'd0;
                        score_ones <= 4'd0;
                        lives      <= LIVES_V;
                        time_left  <= FRAMES_V;
                    end
                end

                S_PLAY: begin
                    score      <= score_nx;
                    score_tens <= tens_nx;
                    score_ones <= ones_nx;
                    lives      <= lives_nx;
                    time_left  <= time_nx;
                    // win is checked first so a simultaneous win+loss is a win
                    if (score_nx == WIN_V) begin
                        state      <= S_WON;
                        is_playing <= 1'b0;
                        is_won     <= 1'b1;
                        hold_cnt   <= '0;
                    end else if ((lives_nx == 3'd0) || (time_nx == 11'd0)) begin
                        state      <= S_LOST;
                        is_playing <= 1'b0;
                        is_lost    <= 1'b1;
                        hold_cnt   <= '0;
                    end
                end

                S_WON, S_LOST: begin
                    // results stay frozen; only the hold timer moves
                    if (start_edge && (hold_cnt == HOLD_MAX)) begin
                        state   <= S_IDLE;
                        is_won  <= 1'b0;
                        is_lost <= 1'b0;
                    end else if (tick && (hold_cnt < HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    is_playing <= 1'b0;
                    is_won     <= 1'b0;
                    is_lost    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Two instances share one stimulus stream: dut_a uses a short round timer and
// the default end-screen hold, dut_b a win score of 99 and a short hold. A
// behavioural model per instance is stepped on every Clk edge and compared
// against all outputs on every falling edge; directed literal checks pin the
// key scenarios, then a randomized phase exercises arbitrary interleavings.
// -----------------------------------------------------------------------------
module tb_game_state_ctrl;

    localparam int A_WIN = 20, A_LIV = 3, A_RF = 5,    A_EH = 120;
    localparam int B_WIN = 99, B_LIV = 3, B_RF = 2047, B_EH = 4;

    logic Clk = 1'b0;
    logic Reset, frame_clk, start, point_pulse, hit_pulse;

    logic        a_pl, a_won, a_lost, b_pl, b_won, b_lost;
    logic [6:0]  a_score, b_score;
    logic [3:0]  a_tens, a_ones, b_tens, b_ones;
    logic [2:0]  a_lives, b_lives;
    logic [10:0] a_time, b_time;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 Clk = ~Clk;

    game_state_ctrl #(.WIN_SCORE(A_WIN), .START_LIVES(A_LIV),
                      .ROUND_FRAMES(A_RF), .END_HOLD_FRAMES(A_EH)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .point_pulse(point_pulse), .hit_pulse(hit_pulse),
        .is_playing(a_pl), .is_won(a_won), .is_lost(a_lost),
        .score(a_score), .score_tens(a_tens), .score_ones(a_ones),
        .lives(a_lives), .time_left(a_time));

    game_state_ctrl #(.WIN_SCORE(B_WIN), .START_LIVES(B_LIV),
                      .ROUND_FRAMES(B_RF), .END_HOLD_FRAMES(B_EH)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .point_pulse(point_pulse), .hit_pulse(hit_pulse),
        .is_playing(b_pl), .is_won(b_won), .is_lost(b_lost),
        .score(b_score), .score_tens(b_tens), .score_ones(b_ones),
        .lives(b_lives), .time_left(b_time));

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 playing, 2 won, 3 lost
    typedef struct {
        int phase;
        int score;
        int lives;
        int tl;
        int frames_shown;
        bit prev_start;
        bit prev_frame;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, bit rst, bit fr, bit st, bit pt, bit ht,
                                  int win, int liv, int rf, int eh);
        bit new_frame, pressed;
        if (rst) begin
            m.phase = 0; m.score = 0; m.lives = liv; m.tl = rf;
            m.frames_shown = 0; m.prev_start = 0; m.prev_frame = 0;
            return m;
        end
        new_frame = fr && !m.prev_frame;
        pressed   = st && !m.prev_start;
        m.prev_frame = fr;
        m.prev_start = st;
        if (m.phase == 0) begin
            if (pressed) begin
                m.phase = 1; m.score = 0; m.lives = liv; m.tl = rf;
            end
        end else if (m.phase == 1) begin
            if (pt) m.score = (m.score + 1 > 99) ? 99 : m.score + 1;
            if (ht) m.lives = (m.lives > 0) ? m.lives - 1 : 0;
            if (new_frame) m.tl = (m.tl > 0) ? m.tl - 1 : 0;
            if (m.score == win) begin
                m.phase = 2; m.frames_shown = 0;
            end else if (m.lives == 0 || m.tl == 0) begin
                m.phase = 3; m.frames_shown = 0;
            end
        end else begin
            if (pressed && m.frames_shown >= eh) m.phase = 0;
            else if (new_frame && m.frames_shown < eh) m.frames_shown++;
        end
        return m;
    endfunction

    always @(posedge Clk) begin
        ma = step(ma, Reset, frame_clk, start, point_pulse, hit_pulse, A_WIN, A_LIV, A_RF, A_EH);
        mb = step(mb, Reset, frame_clk, start, point_pulse, hit_pulse, B_WIN, B_LIV, B_RF, B_EH);
    end

    task automatic cmp_out(string nm, mdl_t m, logic pl, logic wn, logic ls,
                           logic [6:0] sc, logic [3:0] tn, logic [3:0] on,
                           logic [2:0] lv, logic [10:0] tl);
        logic [2:0] ef;
        logic [3:0] et, eo;
        ef = {m.phase == 1, m.phase == 2, m.phase == 3};
        et = 4'(m.score / 10);
        eo = 4'(m.score % 10);
        checks++;
        if ({pl, wn, ls} !== ef || sc !== 7'(m.score) || tn !== et || on !== eo ||
            lv !== 3'(m.lives) || tl !== 11'(m.tl)) begin
            errors++;
            $display("FAIL %s t=%0t got flags=%b score=%0d bcd=%0d%0d lives=%0d time=%0d required flags=%b score=%0d bcd=%0d%0d lives=%0d time=%0d",
                     nm, $time, {pl, wn, ls}, sc, tn, on, lv, tl, ef, m.score, et, eo, m.lives, m.tl);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp_out("model_a", ma, a_pl, a_won, a_lost, a_score, a_tens, a_ones, a_lives, a_time);
            cmp_out("model_b", mb, b_pl, b_won, b_lost, b_score, b_tens, b_ones, b_lives, b_time);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    // inputs change 2 time units after the rising edge
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            frame_clk = 1'b1; cyc(1); frame_clk = 1'b0; cyc(1);
        end
    endtask

    task automatic points(int n);
        repeat (n) begin
            point_pulse = 1'b1; cyc(1); point_pulse = 1'b0; cyc(1);
        end
    endtask

    // leave an end screen (either result) and begin a fresh round
    task automatic restart();
        ticks(A_EH);
        pulse_start();
        pulse_start();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; point_pulse = 1'b0; hit_pulse = 1'b0;
        cyc(1);
        chk_en = 1;
        cyc(1);
        chk("rst_flags", {a_pl, a_won, a_lost}, 3'b000);
        chk("rst_score", a_score, 0);
        chk("rst_lives", a_lives, 3);
        chk("rst_time", a_time, 5);
        Reset = 1'b0;
        cyc(1);

        // win by reaching 20 points
        pulse_start();
        chk("start_play", a_pl, 1);
        for (int i = 0; i < 20; i++) begin
            point_pulse = 1'b1; cyc(1); point_pulse = 1'b0;
            if (i == 18) begin
                chk("pts19_playing", a_pl, 1);
                chk("pts19_won", a_won, 0);
            end
            cyc(1);
        end
        chk("win_score", a_score, 20);
        chk("win_tens", a_tens, 2);
        chk("win_ones", a_ones, 0);
        chk("win_flag", a_won, 1);
        chk("win_play_drop", a_pl, 0);
        chk("model_pin_score", ma.score, 20);

        // end-screen hold
        ticks(50);
        pulse_start();
        chk("hold50_stays_won", a_won, 1);
        ticks(70);
        pulse_start();
        chk("hold120_idle_flags", {a_pl, a_won, a_lost}, 3'b000);
        chk("idle_keeps_score", a_score, 20);
        pulse_start();
        chk("replay_flag", a_pl, 1);
        chk("replay_score", a_score, 0);
        chk("replay_lives", a_lives, 3);
        chk("replay_time", a_time, 5);

        // three hits
        for (int i = 0; i < 3; i++) begin
            hit_pulse = 1'b1; cyc(1); hit_pulse = 1'b0;
            chk("hit_lives", a_lives, 32'(2 - i));
            chk("hit_lost_flag", a_lost, (i == 2) ? 1 : 0);
            cyc(1);
        end
        points(1);
        chk("lost_ignores_point", a_score, 0);
        chk("model_pin_lives", ma.lives, 0);

        // timer runs out; a held frame_clk counts once
        restart();
        chk("timer_round_play", a_pl, 1);
        frame_clk = 1'b1; cyc(6);
        chk("frame_held_once", a_time, 4);
        frame_clk = 1'b0; cyc(1);
        ticks(4);
        chk("timeout_time", a_time, 0);
        chk("timeout_lost", a_lost, 1);

        // point and last hit in the same cycle
        restart();
        points(19);
        repeat (2) begin
            hit_pulse = 1'b1; cyc(1); hit_pulse = 1'b0; cyc(1);
        end
        chk("same_pre_lives", a_lives, 1);
        point_pulse = 1'b1; hit_pulse = 1'b1; cyc(1);
        point_pulse = 1'b0; hit_pulse = 1'b0;
        chk("same_won", a_won, 1);
        chk("same_lost", a_lost, 0);
        chk("same_lives", a_lives, 0);
        chk("same_score", a_score, 20);
        cyc(1);

        // reset mid-round
        restart();
        points(9);
        chk("mid_score", a_score, 9);
        Reset = 1'b1; cyc(1); Reset = 1'b0;
        chk("midrst_flags", {a_pl, a_won, a_lost}, 3'b000);
        chk("midrst_score", a_score, 0);
        chk("midrst_bcd", {a_tens, a_ones}, 8'h00);
        chk("midrst_lives", a_lives, 3);
        chk("midrst_time", a_time, 5);
        cyc(1);

        // score ceiling on the WIN_SCORE=99 instance
        pulse_start();
        points(105);
        chk("sat_score", b_score, 99);
        chk("sat_tens", b_tens, 9);
        chk("sat_ones", b_ones, 9);
        chk("sat_won", b_won, 1);
        chk("sat_other_frozen", a_score, 20);

        // randomized phase, checked every cycle against the model
        for (int i = 0; i < 20000; i++) begin
            Reset       = ($urandom_range(0, 2999) == 0);
            frame_clk   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) start = ~start;
            point_pulse = ($urandom_range(0, 3) == 0);
            hit_pulse   = ($urandom_range(0, 11) == 0);
            cyc(1);
        end
        Reset = 1'b0; point_pulse = 1'b0; hit_pulse = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
